// File: rtl/cpu_mem_arbiter_if.sv
// Bus bundle for cpu_mem_arbiter: CPU port, external req/ack port, memory data port.
// No latency of its own; it only groups wires.
// Backpressure is carried by cpu_stall (CPU side) and ext_ack (external side).
interface cpu_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_ack;
  logic [DATA_W-1:0] ext_rdata;

  logic              addr_err;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_ack, ext_rdata,
    output addr_err,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requesters plus memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_ack, ext_rdata,
    input  addr_err,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Shares the CPU memory data port between the MEM stage (priority) and an external requester.
// CPU: zero added latency; external: grant cycle N, ext_ack/ext_rdata registered in N+1.
// CPU stalls only on a forced external slot; external waits (req held) until ext_ack.
// Optional starvation guard: define CPU_MEM_ARB_STARVE_GUARD_EN.
module cpu_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_DEPTH  = 64,
  parameter int STARVE_MAX = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  cpu_mem_arbiter_if.slave   bus
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

  // The guard counter needs at least one lost cycle before forcing a slot.
  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("cpu_mem_arbiter: STARVE_MAX must be at least 1");
  end

  typedef enum logic {ST_IDLE = 1'b0, ST_ACK = 1'b1} state_t;

  state_t            state_q;
  logic              ext_ack_q;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
  logic              addr_err_q, addr_err_d;

  logic cpu_in_rng, ext_in_rng;
  logic cpu_gnt, ext_gnt, force_slot;

  assign cpu_in_rng = ({1'b0, bus.cpu_addr} < DEPTH_LIM);
  assign ext_in_rng = ({1'b0, bus.ext_addr} < DEPTH_LIM);

`ifdef CPU_MEM_ARB_STARVE_GUARD_EN
  localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign force_slot = bus.ext_req & (starve_cnt_q == STARVE_LIM);

  // Count consecutive IDLE cycles the waiting external request lost to the CPU.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.ext_req || ext_gnt) begin
      starve_cnt_d = '0;
    end else if (state_q == ST_IDLE && cpu_gnt && starve_cnt_q != STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  // Strict CPU priority: the external side only gets cycles the CPU leaves idle.
  assign force_slot = 1'b0;
`endif

  // Slot decision and memory port mux; the two grants are mutually exclusive.
  always_comb begin
    cpu_gnt = bus.cpu_req & ~force_slot;
    ext_gnt = (state_q == ST_IDLE) & bus.ext_req & (~bus.cpu_req | force_slot);

    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (cpu_gnt) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (ext_gnt) begin
      bus.mem_addr  = bus.ext_addr;
      bus.mem_wdata = bus.ext_wdata;
    end

    // Gating with rst_n keeps a grant in flight from writing during reset.
    bus.mem_we = ((cpu_gnt & bus.cpu_we & cpu_in_rng) |
                  (ext_gnt & bus.ext_we & ext_in_rng)) & rst_n;

    bus.cpu_rdata = (cpu_gnt & cpu_in_rng & ~bus.cpu_we) ? bus.mem_rdata : '0;
    bus.cpu_stall = bus.cpu_req & ~cpu_gnt;

    ext_rdata_d = (ext_in_rng & ~bus.ext_we) ? bus.mem_rdata : '0;
    addr_err_d  = addr_err_q | (cpu_gnt & ~cpu_in_rng) | (ext_gnt & ~ext_in_rng);
  end

  // External handshake FSM with registered ack/read data and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ext_ack_q   <= 1'b0;
      ext_rdata_q <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      addr_err_q <= addr_err_d;
      ext_ack_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ext_gnt) begin
            state_q     <= ST_ACK;
            ext_ack_q   <= 1'b1;
            ext_rdata_q <= ext_rdata_d;
          end
        end
        ST_ACK:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ext_ack   = ext_ack_q;
  assign bus.ext_rdata = ext_rdata_q;
  assign bus.addr_err  = addr_err_q;

endmodule
